// File: rtl/alu_op_decode_idex.sv
// rtl/alu_op_decode_idex.sv - ID/EX stage: ALU opcode/operand decode and pipeline latch
// Optional: SHIFT_VARIABLE_EN enables sllv/srlv/srav decode.
module alu_op_decode_idex #(
  parameter int          DATA_W   = 32,
  parameter logic [4:0]  RESET_OP = 5'b00000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_instr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic [4:0]        ex_alu_op,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_arg1,
  output logic [DATA_W-1:0] ex_arg2,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [4:0]        ex_dest,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_illegal
);

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_NOR = 5'b00100;
  localparam logic [4:0] ALU_SLL = 5'b00101;
  localparam logic [4:0] ALU_SRL = 5'b00110;
  localparam logic [4:0] ALU_SRA = 5'b00111;
  localparam logic [4:0] ALU_SLT = 5'b01000;

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rt;
  logic [4:0]        w_rd;
  logic [4:0]        w_sh;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;

  assign w_opcode = id_instr[31:26];
  assign w_rt     = id_instr[20:16];
  assign w_rd     = id_instr[15:11];
  assign w_sh     = id_instr[10:6];
  assign w_funct  = id_instr[5:0];
  assign w_imm    = id_instr[15:0];
  assign w_sext   = {{(DATA_W-16){w_imm[15]}}, w_imm};
  assign w_zext   = {{(DATA_W-16){1'b0}}, w_imm};

  logic [4:0]        w_alu_op;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_arg1;
  logic [DATA_W-1:0] w_arg2;
  logic [4:0]        w_dest;
  logic              w_wr;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_branch;
  logic              w_illegal;
  logic              w_reg_write;

  always_comb begin
    w_alu_op    = ALU_ADD;
    w_shamt     = 5'd0;
    w_arg1      = id_rs_data;
    w_arg2      = id_rt_data;
    w_dest      = w_rt;
    w_wr        = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    case (w_opcode)
      6'h00: begin
        w_dest = w_rd;
        w_wr   = 1'b1;
        case (w_funct)
          6'h20, 6'h21: w_alu_op = ALU_ADD;
          6'h22, 6'h23: w_alu_op = ALU_SUB;
          6'h24:        w_alu_op = ALU_AND;
          6'h25:        w_alu_op = ALU_OR;
          6'h27:        w_alu_op = ALU_NOR;
          6'h2A:        w_alu_op = ALU_SLT;
          6'h00: begin w_alu_op = ALU_SLL; w_shamt = w_sh; end
          6'h02: begin w_alu_op = ALU_SRL; w_shamt = w_sh; end
          6'h03: begin w_alu_op = ALU_SRA; w_shamt = w_sh; end
`ifdef SHIFT_VARIABLE_EN
          6'h04: begin w_alu_op = ALU_SLL; w_shamt = id_rs_data[4:0]; end
          6'h06: begin w_alu_op = ALU_SRL; w_shamt = id_rs_data[4:0]; end
          6'h07: begin w_alu_op = ALU_SRA; w_shamt = id_rs_data[4:0]; end
`endif
          default: begin w_illegal = 1'b1; w_wr = 1'b0; end
        endcase
      end
      6'h08, 6'h09: begin w_arg2 = w_sext; w_wr = 1'b1; end
      6'h0A: begin w_alu_op = ALU_SLT; w_arg2 = w_sext; w_wr = 1'b1; end
      6'h0C: begin w_alu_op = ALU_AND; w_arg2 = w_zext; w_wr = 1'b1; end
      6'h0D: begin w_alu_op = ALU_OR;  w_arg2 = w_zext; w_wr = 1'b1; end
      6'h0F: begin
        w_arg1 = '0;
        w_arg2 = {w_imm, 16'h0000};
        w_wr   = 1'b1;
      end
      6'h23: begin w_arg2 = w_sext; w_wr = 1'b1; w_mem_read = 1'b1; end
      6'h2B: begin w_arg2 = w_sext; w_mem_write = 1'b1; end
      6'h04: begin w_alu_op = ALU_SUB; w_branch = 1'b1; end
      default: w_illegal = 1'b1;
    endcase
  end

  // $zero is never written, so a no-op like 0x00000000 is a harmless valid sll
  assign w_reg_write = w_wr && (w_dest != 5'd0);

  logic              r_valid;
  logic [4:0]        r_alu_op;
  logic [4:0]        r_shamt;
  logic [DATA_W-1:0] r_arg1;
  logic [DATA_W-1:0] r_arg2;
  logic [DATA_W-1:0] r_store_data;
  logic [4:0]        r_dest;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;
  logic              r_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_valid      <= 1'b0;
      r_alu_op     <= RESET_OP;
      r_shamt      <= 5'd0;
      r_arg1       <= '0;
      r_arg2       <= '0;
      r_store_data <= '0;
      r_dest       <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_branch     <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (!stall) begin
      r_valid      <= id_valid;
      r_alu_op     <= w_alu_op;
      r_shamt      <= w_shamt;
      r_arg1       <= w_arg1;
      r_arg2       <= w_arg2;
      r_store_data <= id_rt_data;
      r_dest       <= w_dest;
      r_reg_write  <= id_valid && w_reg_write;
      r_mem_read   <= id_valid && w_mem_read;
      r_mem_write  <= id_valid && w_mem_write;
      r_branch     <= id_valid && w_branch;
      r_illegal    <= id_valid && w_illegal;
    end
  end

  assign ex_valid      = r_valid;
  assign ex_alu_op     = r_alu_op;
  assign ex_shamt      = r_shamt;
  assign ex_arg1       = r_arg1;
  assign ex_arg2       = r_arg2;
  assign ex_store_data = r_store_data;
  assign ex_dest       = r_dest;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_branch     = r_branch;
  assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_alu_op_decode_idex.sv
// tb/tb_alu_op_decode_idex.sv - directed-vector bench for alu_op_decode_idex
module tb_alu_op_decode_idex;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_alu_op;
  logic [4:0]  ex_shamt;
  logic [31:0] ex_arg1;
  logic [31:0] ex_arg2;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_op_decode_idex dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall), .flush(flush),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_shamt(ex_shamt),
    .ex_arg1(ex_arg1), .ex_arg2(ex_arg2), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic apply(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
    id_instr   = instr;
    id_rs_data = rs;
    id_rt_data = rt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_ctl(input string tag, input logic v, input logic rw, input logic mr,
                           input logic mw, input logic br, input logic il);
    check({tag, ".valid"},     {31'd0, ex_valid},     {31'd0, v});
    check({tag, ".reg_write"}, {31'd0, ex_reg_write}, {31'd0, rw});
    check({tag, ".mem_read"},  {31'd0, ex_mem_read},  {31'd0, mr});
    check({tag, ".mem_write"}, {31'd0, ex_mem_write}, {31'd0, mw});
    check({tag, ".branch"},    {31'd0, ex_branch},    {31'd0, br});
    check({tag, ".illegal"},   {31'd0, ex_illegal},   {31'd0, il});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0; id_valid = 1'b1;
    id_instr = 32'h0; id_rs_data = 32'h0; id_rt_data = 32'h0;
    @(negedge clk);

    apply(32'h012A4020, 32'd5, 32'd7);
    check_ctl("reset", 0, 0, 0, 0, 0, 0);
    check("reset.alu_op", {27'd0, ex_alu_op}, 32'd0);
    check("reset.arg1", ex_arg1, 32'd0);
    check("reset.dest", {27'd0, ex_dest}, 32'd0);

    rst_n = 1'b1; stall = 1'b0;
    apply(32'h012A4020, 32'd5, 32'd7);
    check_ctl("add", 1, 1, 0, 0, 0, 0);
    check("add.alu_op", {27'd0, ex_alu_op}, 32'd0);
    check("add.arg1", ex_arg1, 32'd5);
    check("add.arg2", ex_arg2, 32'd7);
    check("add.dest", {27'd0, ex_dest}, 32'd8);
    check("add.shamt", {27'd0, ex_shamt}, 32'd0);

    apply(32'h012A4022, 32'd5, 32'd7);
    check("sub.alu_op", {27'd0, ex_alu_op}, 32'd1);
    apply(32'h012A402A, 32'd5, 32'd7);
    check("slt.alu_op", {27'd0, ex_alu_op}, 32'd8);
    apply(32'h012A4027, 32'd5, 32'd7);
    check("nor.alu_op", {27'd0, ex_alu_op}, 32'd4);
    apply(32'h012A0020, 32'd5, 32'd7);
    check_ctl("add_rd0", 1, 0, 0, 0, 0, 0);

    apply(32'h2128FFFF, 32'd5, 32'd7);
    check("addi.arg2", ex_arg2, 32'hFFFFFFFF);
    check("addi.dest", {27'd0, ex_dest}, 32'd8);
    check("addi.alu_op", {27'd0, ex_alu_op}, 32'd0);
    check_ctl("addi", 1, 1, 0, 0, 0, 0);

    apply(32'h3528FFFF, 32'd5, 32'd7);
    check("ori.arg2", ex_arg2, 32'h0000FFFF);
    check("ori.alu_op", {27'd0, ex_alu_op}, 32'd3);
    apply(32'h3128FFFF, 32'd5, 32'd7);
    check("andi.alu_op", {27'd0, ex_alu_op}, 32'd2);
    apply(32'h29288005, 32'd5, 32'd7);
    check("slti.alu_op", {27'd0, ex_alu_op}, 32'd8);
    check("slti.arg2", ex_arg2, 32'hFFFF8005);

    apply(32'h3C081234, 32'd5, 32'd7);
    check("lui.arg1", ex_arg1, 32'd0);
    check("lui.arg2", ex_arg2, 32'h12340000);

    apply(32'h00094103, 32'd5, 32'd7);
    check("sra.alu_op", {27'd0, ex_alu_op}, 32'd7);
    check("sra.shamt", {27'd0, ex_shamt}, 32'd4);
    check("sra.arg2", ex_arg2, 32'd7);
    apply(32'h00094102, 32'd5, 32'd7);
    check("srl.alu_op", {27'd0, ex_alu_op}, 32'd6);

    apply(32'h112A0003, 32'd5, 32'd7);
    check("beq.alu_op", {27'd0, ex_alu_op}, 32'd1);
    check("beq.arg2", ex_arg2, 32'd7);
    check_ctl("beq", 1, 0, 0, 0, 1, 0);

    apply(32'hAD2A0008, 32'd5, 32'd7);
    check_ctl("sw", 1, 0, 0, 1, 0, 0);
    check("sw.store_data", ex_store_data, 32'd7);
    check("sw.arg2", ex_arg2, 32'd8);

    apply(32'h8D28FFFC, 32'd5, 32'd7);
    check_ctl("lw", 1, 1, 1, 0, 0, 0);
    check("lw.arg2", ex_arg2, 32'hFFFFFFFC);

    apply(32'h012A4020, 32'd5, 32'd7);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(32'h3528FFFF + i, 32'd99 + i, 32'd1);
      check("stall.alu_op", {27'd0, ex_alu_op}, 32'd0);
      check("stall.arg1", ex_arg1, 32'd5);
      check("stall.arg2", ex_arg2, 32'd7);
      check_ctl("stall", 1, 1, 0, 0, 0, 0);
    end
    flush = 1'b1;
    apply(32'h3528FFFF, 32'd5, 32'd7);
    check_ctl("flush", 0, 0, 0, 0, 0, 0);
    check("flush.arg2", ex_arg2, 32'd0);
    stall = 1'b0; flush = 1'b0;
    apply(32'h3528FFFF, 32'd5, 32'd7);
    check("resume.alu_op", {27'd0, ex_alu_op}, 32'd3);
    check("resume.valid", {31'd0, ex_valid}, 32'd1);

    apply(32'h00000000, 32'd5, 32'd7);
    check_ctl("nop", 1, 0, 0, 0, 0, 0);
    check("nop.alu_op", {27'd0, ex_alu_op}, 32'd5);

    apply(32'hFC000000, 32'd5, 32'd7);
    check_ctl("illegal", 1, 0, 0, 0, 0, 1);
    check("illegal.alu_op", {27'd0, ex_alu_op}, 32'd0);
    apply(32'h012A4001, 32'd5, 32'd7);
    check_ctl("bad_funct", 1, 0, 0, 0, 0, 1);

    id_valid = 1'b0;
    apply(32'hAD2A0008, 32'd5, 32'd7);
    check_ctl("invalid", 0, 0, 0, 0, 0, 0);
    id_valid = 1'b1;

    apply(32'h01494007, 32'd35, 32'd7);
`ifdef SHIFT_VARIABLE_EN
    check_ctl("srav", 1, 1, 0, 0, 0, 0);
    check("srav.alu_op", {27'd0, ex_alu_op}, 32'd7);
    check("srav.shamt", {27'd0, ex_shamt}, 32'd3);
`else
    check_ctl("srav", 1, 0, 0, 0, 0, 1);
    check("srav.alu_op", {27'd0, ex_alu_op}, 32'd0);
`endif

    apply(32'h012A4020, 32'd5, 32'd7);
    stall = 1'b1;
    apply(32'h012A4020, 32'd5, 32'd7);
    rst_n = 1'b0;
    apply(32'h012A4020, 32'd5, 32'd7);
    check_ctl("reset_in_stall", 0, 0, 0, 0, 0, 0);
    check("reset_in_stall.arg1", ex_arg1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
